// File: rtl/memory_arbiter_pkg.sv
// Shared widths and encodings for the IF/LS memory-port arbiter.
// The round-robin pick lives here so the policy is stated exactly once.
package memory_arbiter_pkg;

  localparam int LEN_MEM_ADDR = 16;
  localparam int LEN_WORD     = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Sole requester wins; on a tie the one not granted last wins.
  function automatic owner_e rr_pick(input logic if_req, input logic ls_req,
                                     input owner_e last);
    if (if_req && ls_req) return (last == OWN_IF) ? OWN_LS : OWN_IF;
    return ls_req ? OWN_LS : OWN_IF;
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Two-way round-robin arbiter sharing one memory port between instruction
// fetch (read-only) and load/store, one outstanding transaction at a time.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [LEN_MEM_ADDR-1:0] if_addr,
  output logic                    if_done,
  output logic [LEN_WORD-1:0]     if_rdata,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [LEN_MEM_ADDR-1:0] ls_addr,
  input  logic [LEN_WORD-1:0]     ls_wdata,
  output logic                    ls_done,
  output logic [LEN_WORD-1:0]     ls_rdata,
  output logic                    mem_order,
  output logic                    mem_io,
  output logic [LEN_MEM_ADDR-1:0] mem_address,
  output logic [LEN_WORD-1:0]     mem_i_data,
  input  logic                    mem_accepted,
  input  logic                    mem_accessed,
  input  logic [LEN_WORD-1:0]     mem_o_data
);

  // "Last granted" starts as the other side so INIT_PRIO wins the first tie.
  localparam owner_e LAST_RESET = INIT_PRIO ? OWN_IF : OWN_LS;

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  owner_e                  last_q, last_d;
  logic                    io_q, io_d;
  logic [LEN_MEM_ADDR-1:0] addr_q, addr_d;
  logic [LEN_WORD-1:0]     wdata_q, wdata_d;
  logic                    order_q, order_d;
  logic                    if_done_q, if_done_d;
  logic                    ls_done_q, ls_done_d;
  logic [LEN_WORD-1:0]     if_rdata_q, if_rdata_d;
  logic [LEN_WORD-1:0]     ls_rdata_q, ls_rdata_d;
  logic                    finish;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    io_d       = io_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    order_d    = order_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    finish     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (if_req || ls_req) begin
          owner_d = rr_pick(if_req, ls_req, last_q);
          last_d  = owner_d;
          order_d = 1'b1;
          state_d = ARB_ISSUE;
          if (owner_d == OWN_LS) begin
            io_d    = ls_we;
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
          end else begin
            io_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end
      end
      ARB_ISSUE: begin
        if (mem_accepted) begin
          order_d = 1'b0;
          finish  = mem_accessed;
          state_d = mem_accessed ? ARB_DONE : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_accessed) begin
          finish  = 1'b1;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    // Done pulse and read data are registered so they appear in the DONE cycle.
    if (finish) begin
      if_done_d = (owner_q == OWN_IF);
      ls_done_d = (owner_q == OWN_LS);
      if (!io_q) begin
        if (owner_q == OWN_IF) if_rdata_d = mem_o_data;
        else                   ls_rdata_d = mem_o_data;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IF;
      last_q     <= LAST_RESET;
      io_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      order_q    <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      io_q       <= io_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      order_q    <= order_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_order   = order_q;
  assign mem_io      = io_q;
  assign mem_address = addr_q;
  assign mem_i_data  = wdata_q;
  assign if_done     = if_done_q;
  assign ls_done     = ls_done_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter; the bench plays both
// requesters and the memory, cycle by cycle.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    if_req = 1'b0;
  logic [LEN_MEM_ADDR-1:0] if_addr = '0;
  logic                    if_done;
  logic [LEN_WORD-1:0]     if_rdata;
  logic                    ls_req = 1'b0;
  logic                    ls_we = 1'b0;
  logic [LEN_MEM_ADDR-1:0] ls_addr = '0;
  logic [LEN_WORD-1:0]     ls_wdata = '0;
  logic                    ls_done;
  logic [LEN_WORD-1:0]     ls_rdata;
  logic                    mem_order;
  logic                    mem_io;
  logic [LEN_MEM_ADDR-1:0] mem_address;
  logic [LEN_WORD-1:0]     mem_i_data;
  logic                    mem_accepted = 1'b0;
  logic                    mem_accessed = 1'b0;
  logic [LEN_WORD-1:0]     mem_o_data = '0;

  int errors = 0;
  int checks = 0;

  memory_arbiter #(.INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_order(mem_order), .mem_io(mem_io), .mem_address(mem_address),
    .mem_i_data(mem_i_data), .mem_accepted(mem_accepted),
    .mem_accessed(mem_accessed), .mem_o_data(mem_o_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " order"}, 64'(mem_order), 64'd0);
    check({tag, " io"}, 64'(mem_io), 64'd0);
    check({tag, " addr"}, 64'(mem_address), 64'd0);
    check({tag, " idata"}, 64'(mem_i_data), 64'd0);
    check({tag, " if_done"}, 64'(if_done), 64'd0);
    check({tag, " ls_done"}, 64'(ls_done), 64'd0);
    check({tag, " if_rdata"}, 64'(if_rdata), 64'd0);
    check({tag, " ls_rdata"}, 64'(ls_rdata), 64'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_idle_outputs("reset");
    check("reset state", 64'(dut.state_q), 64'(ARB_IDLE));
    rst = 1'b0;

    // Single IF read: accepted cycle 1, accessed cycle 3, done cycle 4
    if_req = 1'b1; if_addr = 16'h0010;
    step();                                   // cycle 1
    check("if1 order c1", 64'(mem_order), 64'd1);
    check("if1 addr", 64'(mem_address), 64'h10);
    check("if1 io", 64'(mem_io), 64'd0);
    check("if1 ls_done c1", 64'(ls_done), 64'd0);
    if_req = 1'b0; mem_accepted = 1'b1;
    step();                                   // cycle 2
    check("if1 order c2", 64'(mem_order), 64'd0);
    check("if1 if_done c2", 64'(if_done), 64'd0);
    mem_accepted = 1'b0;
    step();                                   // cycle 3
    check("if1 order c3", 64'(mem_order), 64'd0);
    check("if1 if_done c3", 64'(if_done), 64'd0);
    mem_accessed = 1'b1; mem_o_data = 32'hDEADBEEF;
    step();                                   // cycle 4
    check("if1 if_done c4", 64'(if_done), 64'd1);
    check("if1 rdata", 64'(if_rdata), 64'hDEADBEEF);
    check("if1 ls_done c4", 64'(ls_done), 64'd0);
    mem_accessed = 1'b0;
    step();                                   // cycle 5
    check("if1 if_done c5", 64'(if_done), 64'd0);
    check("if1 order c5", 64'(mem_order), 64'd0);

    // Zero-wait LS load: done in cycle 2, WAIT never visited
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0030;
    step();                                   // cycle 1
    check("zw state c1", 64'(dut.state_q), 64'(ARB_ISSUE));
    check("zw order c1", 64'(mem_order), 64'd1);
    ls_req = 1'b0; mem_accepted = 1'b1; mem_accessed = 1'b1; mem_o_data = 32'hCAFEF00D;
    step();                                   // cycle 2
    check("zw state c2", 64'(dut.state_q), 64'(ARB_DONE));
    check("zw ls_done", 64'(ls_done), 64'd1);
    check("zw ls_rdata", 64'(ls_rdata), 64'hCAFEF00D);
    check("zw if_rdata kept", 64'(if_rdata), 64'hDEADBEEF);
    check("zw order c2", 64'(mem_order), 64'd0);
    mem_accepted = 1'b0; mem_accessed = 1'b0;
    step();
    check("zw ls_done drop", 64'(ls_done), 64'd0);

    // LS store: write fields driven, load data register untouched
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 32'h12345678;
    step();
    check("st order", 64'(mem_order), 64'd1);
    check("st io", 64'(mem_io), 64'd1);
    check("st addr", 64'(mem_address), 64'h20);
    check("st idata", 64'(mem_i_data), 64'h12345678);
    ls_req = 1'b0; ls_we = 1'b0;
    mem_accepted = 1'b1; mem_accessed = 1'b1; mem_o_data = 32'h0BAD0BAD;
    step();
    check("st ls_done", 64'(ls_done), 64'd1);
    check("st if_done", 64'(if_done), 64'd0);
    check("st ls_rdata kept", 64'(ls_rdata), 64'hCAFEF00D);
    mem_accepted = 1'b0; mem_accessed = 1'b0;
    step();
    check("st ls_done once", 64'(ls_done), 64'd0);

    // Round robin after reset: both held, zero-wait memory, IF LS IF LS
    rst = 1'b1;
    step();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0200;
    mem_accepted = 1'b1; mem_accessed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_o_data = 32'h1000 + 32'(i);
      step();                                 // ISSUE
      check($sformatf("rr%0d addr", i), 64'(mem_address), (i % 2 == 0) ? 64'h100 : 64'h200);
      step();                                 // DONE
      check($sformatf("rr%0d if_done", i), 64'(if_done), (i % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d ls_done", i), 64'(ls_done), (i % 2 == 0) ? 64'd0 : 64'd1);
      if (i % 2 == 0) check($sformatf("rr%0d if_rdata", i), 64'(if_rdata), 64'h1000 + 64'(i));
      else            check($sformatf("rr%0d ls_rdata", i), 64'(ls_rdata), 64'h1000 + 64'(i));
      step();                                 // IDLE
    end
    if_req = 1'b0; ls_req = 1'b0;
    mem_accepted = 1'b0; mem_accessed = 1'b0;
    step();

    // Accept delayed 3 cycles while the requester changes its address
    if_req = 1'b1; if_addr = 16'h0040;
    step();                                   // cycle 1
    check("dly order c1", 64'(mem_order), 64'd1);
    check("dly addr c1", 64'(mem_address), 64'h40);
    if_req = 1'b0; if_addr = 16'h0044;
    step();                                   // cycle 2
    check("dly order c2", 64'(mem_order), 64'd1);
    check("dly addr c2", 64'(mem_address), 64'h40);
    if_addr = 16'h0048;
    step();                                   // cycle 3
    check("dly order c3", 64'(mem_order), 64'd1);
    check("dly addr c3", 64'(mem_address), 64'h40);
    mem_accepted = 1'b1;
    step();                                   // cycle 4: WAIT
    check("dly order c4", 64'(mem_order), 64'd0);
    check("dly state c4", 64'(dut.state_q), 64'(ARB_WAIT));
    mem_accepted = 1'b0;

    // Reset in WAIT: all outputs cleared, stray accessed ignored
    rst = 1'b1;
    step();
    check_idle_outputs("rstwait");
    check("rstwait state", 64'(dut.state_q), 64'(ARB_IDLE));
    rst = 1'b0; mem_accessed = 1'b1; mem_o_data = 32'hFFFF0000;
    step();
    check("stray if_done 1", 64'(if_done), 64'd0);
    check("stray ls_done 1", 64'(ls_done), 64'd0);
    step();
    check("stray if_done 2", 64'(if_done), 64'd0);
    check("stray ls_done 2", 64'(ls_done), 64'd0);
    check("stray if_rdata", 64'(if_rdata), 64'd0);
    mem_accessed = 1'b0;

    // Fresh LS load completes normally after the reset
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0050;
    step();
    check("fresh order", 64'(mem_order), 64'd1);
    check("fresh addr", 64'(mem_address), 64'h50);
    ls_req = 1'b0; mem_accepted = 1'b1;
    step();
    check("fresh ls_done early", 64'(ls_done), 64'd0);
    mem_accepted = 1'b0; mem_accessed = 1'b1; mem_o_data = 32'h000055AA;
    step();
    check("fresh ls_done", 64'(ls_done), 64'd1);
    check("fresh ls_rdata", 64'(ls_rdata), 64'h55AA);
    mem_accessed = 1'b0;
    step();
    check("fresh ls_done drop", 64'(ls_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
